// File: rtl/btn_pkg.sv
// Shared types and 100 MHz default limits for push-button conditioning logic.
package btn_pkg;

  typedef enum logic [1:0] {
    S_RELEASED,
    S_PRESS_PEND,
    S_PRESSED,
    S_RELEASE_PEND
  } btn_state_t;

  localparam int DEF_DEBOUNCE_LIMIT   = 1_000_000;    // 10 ms at 100 MHz
  localparam int DEF_LONG_PRESS_LIMIT = 100_000_000;  // 1 s at 100 MHz

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous pin inputs.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] sync_p0;
  logic [WIDTH-1:0] sync_p1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= i_d;
      sync_p1 <= sync_p0;
    end
  end

  assign o_q = sync_p1;

endmodule

// File: rtl/button_debouncer.sv
// Debounces a raw push-button into a clean level plus press, release and
// long-press single-cycle pulses, all registered.
module button_debouncer
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT   = DEF_DEBOUNCE_LIMIT,
  parameter int LONG_PRESS_LIMIT = DEF_LONG_PRESS_LIMIT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long
);

  localparam int CNT_W  = $clog2(DEBOUNCE_LIMIT + 1);
  localparam int HOLD_W = $clog2(LONG_PRESS_LIMIT + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_LIMIT);

  btn_state_t        state;
  btn_state_t        state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [HOLD_W-1:0] hold;
  logic [HOLD_W-1:0] hold_nxt;
  logic              level_nxt;
  logic              press_nxt;
  logic              release_nxt;
  logic              long_nxt;
  logic              btn_s;

  // Sticks at HOLD_MAX so o_long can only fire once per press.
  function automatic logic [HOLD_W-1:0] sat_inc_hold(input logic [HOLD_W-1:0] v);
    return (v == HOLD_MAX) ? v : v + 1'b1;
  endfunction

  sync_2ff #(
    .WIDTH (1)
  ) u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_btn),
    .o_q   (btn_s)
  );

  // Stage p0: synchronized sample -> next-state decision
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    hold_nxt    = hold;
    level_nxt   = o_level;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    long_nxt    = 1'b0;

    case (state)
      S_RELEASED: begin
        if (btn_s) begin
          state_nxt = S_PRESS_PEND;
          cnt_nxt   = '0;
        end
      end

      S_PRESS_PEND: begin
        if (!btn_s) begin
          state_nxt = S_RELEASED;
        end else if (cnt == CNT_LAST) begin
          state_nxt = S_PRESSED;
          level_nxt = 1'b1;
          press_nxt = 1'b1;
          hold_nxt  = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      S_PRESSED: begin
        if (!btn_s) begin
          state_nxt = S_RELEASE_PEND;
          cnt_nxt   = '0;
        end else begin
          hold_nxt = sat_inc_hold(hold);
          long_nxt = (hold != HOLD_MAX) && (hold_nxt == HOLD_MAX);
        end
      end

      S_RELEASE_PEND: begin
        // A return to 1 resumes the press with hold kept as it was.
        if (btn_s) begin
          state_nxt = S_PRESSED;
        end else if (cnt == CNT_LAST) begin
          state_nxt   = S_RELEASED;
          level_nxt   = 1'b0;
          release_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      default: begin
        state_nxt = S_RELEASED;
      end
    endcase
  end

  // Stage p1: state, counters and registered outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= S_RELEASED;
      cnt       <= '0;
      hold      <= '0;
      o_level   <= 1'b0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_long    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      hold      <= hold_nxt;
      o_level   <= level_nxt;
      o_press   <= press_nxt;
      o_release <= release_nxt;
      o_long    <= long_nxt;
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed self-checking bench for button_debouncer with short limits
// (debounce 4, long press 20).
module tb_button_debouncer;

  localparam int DEB  = 4;
  localparam int LONG = 20;

  logic tb_clk;
  logic i_rst;
  logic i_btn;
  logic o_level;
  logic o_press;
  logic o_release;
  logic o_long;

  int n_chk;
  int n_pass;
  int n_press;
  int n_release;
  int n_long;

  button_debouncer #(
    .DEBOUNCE_LIMIT   (DEB),
    .LONG_PRESS_LIMIT (LONG)
  ) dut (
    .i_clk     (tb_clk),
    .i_rst     (i_rst),
    .i_btn     (i_btn),
    .o_level   (o_level),
    .o_press   (o_press),
    .o_release (o_release),
    .o_long    (o_long)
  );

  initial begin
    tb_clk = 1'b0;
    forever #5 tb_clk = ~tb_clk;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Advance one edge, sample 1 ns later, tally pulses and check exclusivity.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge tb_clk);
      #1;
      n_press   += int'(o_press);
      n_release += int'(o_release);
      n_long    += int'(o_long);
      check("pulse_excl", int'(o_press) + int'(o_release) + int'(o_long) <= 1, 1);
    end
  endtask

  task automatic clr_counts();
    n_press   = 0;
    n_release = 0;
    n_long    = 0;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    clr_counts();
    i_btn = 1'b0;
    i_rst = 1'b1;
    #2;
    check("rst_level",   o_level,   0);
    check("rst_press",   o_press,   0);
    check("rst_release", o_release, 0);
    check("rst_long",    o_long,    0);
    step(2);
    i_rst = 1'b0;
    step(3);
    check("idle_level", o_level, 0);

    // Clean press, then a short press released 10 cycles after o_press
    clr_counts();
    i_btn = 1'b1;
    step(6);
    check("t1_press_e6", o_press, 0);
    check("t1_level_e6", o_level, 0);
    step(1);
    check("t1_press_e7", o_press, 1);
    check("t1_level_e7", o_level, 1);
    step(1);
    check("t1_press_e8", o_press, 0);
    check("t1_level_e8", o_level, 1);
    step(9);
    i_btn = 1'b0;
    step(6);
    check("t5_rel_e6",   o_release, 0);
    check("t5_level_e6", o_level,   1);
    step(1);
    check("t5_rel_e7",   o_release, 1);
    check("t5_level_e7", o_level,   0);
    step(1);
    check("t5_rel_e8", o_release, 0);
    check("t5_n_press",   n_press,   1);
    check("t5_n_release", n_release, 1);
    check("t5_n_long",    n_long,    0);

    // Bounce 1,0,1,0 every 2 cycles, then settle high
    clr_counts();
    for (int k = 0; k < 4; k++) begin
      i_btn = (k % 2 == 0);
      step(2);
    end
    i_btn = 1'b1;
    step(6);
    check("t2_press_e6", o_press, 0);
    check("t2_n_press_pre", n_press, 0);
    step(1);
    check("t2_press_e7", o_press, 1);
    check("t2_n_press",   n_press,   1);
    check("t2_n_release", n_release, 0);

    // Long press: hold 40 cycles past o_press, then release
    clr_counts();
    step(19);
    check("t4_long_19", o_long, 0);
    step(1);
    check("t4_long_20", o_long, 1);
    step(1);
    check("t4_long_21", o_long, 0);
    step(19);
    i_btn = 1'b0;
    step(6);
    check("t4_rel_e6", o_release, 0);
    step(1);
    check("t4_rel_e7",   o_release, 1);
    check("t4_level_e7", o_level,   0);
    step(2);
    check("t4_n_long",    n_long,    1);
    check("t4_n_release", n_release, 1);

    // Release with a 3-cycle low glitch first
    clr_counts();
    i_btn = 1'b1;
    step(7);
    check("t3_press", o_press, 1);
    i_btn = 1'b0;
    step(3);
    i_btn = 1'b1;
    step(8);
    check("t3_level_glitch", o_level,   1);
    check("t3_n_rel_glitch", n_release, 0);
    i_btn = 1'b0;
    step(6);
    check("t3_rel_e6", o_release, 0);
    step(1);
    check("t3_rel_e7",   o_release, 1);
    check("t3_level_e7", o_level,   0);
    step(1);
    check("t3_n_press",   n_press,   1);
    check("t3_n_release", n_release, 1);
    check("t3_n_long",    n_long,    0);

    // Asynchronous reset while pressed, button still held afterwards
    clr_counts();
    i_btn = 1'b1;
    step(7);
    check("t6_press",       o_press, 1);
    check("t6_level_pre",   o_level, 1);
    i_rst = 1'b1;
    #1;
    check("t6_rst_level",   o_level,   0);
    check("t6_rst_press",   o_press,   0);
    check("t6_rst_release", o_release, 0);
    check("t6_rst_long",    o_long,    0);
    step(2);
    i_rst = 1'b0;
    step(6);
    check("t6_press_e6", o_press, 0);
    check("t6_level_e6", o_level, 0);
    step(1);
    check("t6_press_e7", o_press, 1);
    check("t6_level_e7", o_level, 1);
    step(1);
    check("t6_n_press",   n_press,   2);
    check("t6_n_release", n_release, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
